addsub_int_serial: RTL

- Parametrised, digit-serial integer add/subtract unit. It is the sequential successor to the combinational n-bit subtractor.
- Each cycle it processes DIGIT bits of a WIDTH-bit operand pair through one shared DIGIT-bit ripple slice. This trades latency for area, which suits PIM-style bit-serial mapping.
- Supports add or subtract, wrap or saturating (unsigned or signed) result, and carry/borrow and overflow flags.
- Uses valid/ready handshakes on both sides, so it can sit inside pimsynth benchmark pipelines.

---
 rtl/addsub_int_serial.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/addsub_int_serial.sv
// Digit-serial integer add/subtract with wrap/saturating results, carry/borrow and overflow flags.
// One DIGIT-bit ripple slice is reused for N = WIDTH/DIGIT cycles, and valid/ready handshakes sit on both sides.
module addsub_int_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op_sub,
  input  logic [1:0]       sat_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("addsub_int_serial: WIDTH must be >= 2 and divisible by DIGIT, with 1 <= DIGIT <= WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic [1:0]       sat_q, sat_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_v_q, flag_v_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] raw;
  logic             c_out;
  logic             ovf;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    k_d         = k_q;
    sat_d       = sat_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    flag_c_d    = flag_c_q;
    flag_v_d    = flag_v_q;

    a_dig = a_q[k_q*DIGIT +: DIGIT];
    b_dig = b_q[k_q*DIGIT +: DIGIT];
    dsum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    c_out = dsum[DIGIT];
    // raw is the accumulator with the current digit already merged, so the
    // final cycle can derive flags and saturation without an extra stage.
    raw = acc_q;
    raw[k_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
    ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = A;
          b_d        = op_sub ? ~B : B;
          sub_d      = op_sub;
          sat_d      = sat_mode;
          carry_d    = op_sub;
          k_d        = '0;
          acc_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d   = raw;
        carry_d = c_out;
        if (k_q == K_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          flag_c_d    = sub_q ? ~c_out : c_out;
          flag_v_d    = ovf;
          result_d    = raw;
          case (sat_q)
            2'b01: begin
              if (!sub_q && c_out) begin
                result_d = '1;
              end else if (sub_q && !c_out) begin
                result_d = '0;
              end
            end
            2'b10: begin
              if (ovf) begin
                result_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
              end
            end
            default: ;
          endcase
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      k_q         <= '0;
      sat_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      k_q         <= k_d;
      sat_q       <= sat_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;

endmodule
